trap_arbiter: RTL and testbench
===============================

# trap_arbiter

Parametrised trap/interrupt arbiter for the RisKy1 core. It takes the standard M/S/U interrupt sources plus `NUM_LOCAL` platform-local interrupt lines, handles delegation to S mode, and applies fixed priority. Every trap it takes goes through a req/ack handshake with the WB stage. It owns the privilege-mode register and produces the registered trap PC (direct or vectored), the trap cause and the trap target mode.

## Interface
- `NUM_LOCAL`, default 4: local interrupt lines, cause codes 16..16+NUM_LOCAL-1 (1..16 allowed).
- `EDGE_MASK`, default `'0`: per-line select; bit i = 1 means line i is edge-latched, 0 means level.
- `PC_SZ`, default 32: PC width.
- `RSZ`, default 32: register width.
- `clk_in`, in, 1: the only clock.
- `reset_in`, in, 1: synchronous, active-high reset.
- `lirq_in`, in, NUM_LOCAL: raw local interrupt lines.
- `lie`, in, NUM_LOCAL: local interrupt enables.
- `lip_clr`, in, NUM_LOCAL: one-cycle clear of edge-latched pending bits (from a CSR write).
- `lip`, out, NUM_LOCAL: local pending bits, visible to the CSR read path.
- `mip`, in, 12: standard interrupt-pending bits, mip layout.
- `mie`, in, 12: standard interrupt-enable bits, mie layout.
- `mideleg`, in, 12+NUM_LOCAL: delegation to S mode, one bit per interrupt.
- `mstatus_mie`, `mstatus_sie`, `mstatus_uie`, in, 1 each: global interrupt enables.
- `mpp`, in, 2; `spp`, in, 1: saved previous privilege mode.
- `mtvec`, `stvec`, `utvec`, in, RSZ each: trap vectors.
- `exc_flag`, in, 1: synchronous exception from WB.
- `exc_cause`, in, RSZ-1: exception code.
- `mret`, `sret`, `uret`, in, 1 each: return instructions retiring in WB.
- `trap_req`, out, 1: trap pending, waiting for WB.
- `trap_ack`, in, 1: WB takes the trap this cycle.
- `trap_pc`, out, PC_SZ: handler address.
- `trap_cause`, out, RSZ: bit RSZ-1 = interrupt, low bits = code.
- `trap_mode`, out, 2: target privilege mode.
- `mode`, out, 2: current privilege mode.

## Operation
- **Local pending.**
  - Edge line: `lip[i]` sets on a rising edge of `lirq_in[i]`, detected against a one-cycle-delayed copy of the line.
  - `lip[i]` clears on `lip_clr[i]`. If set and clear occur in the same cycle, set wins.
  - Level line: `lip[i]` is a registered copy of `lirq_in[i]`; `lip_clr` has no effect.
- **Candidate interrupt.** An interrupt is a candidate when its pending bit AND its enable bit are set.
- **Target mode.** Target = S when `mideleg` bit = 1 and `mode` != M; otherwise target = M.
- **Eligibility.** A candidate is eligible when target > `mode`, or target == `mode` and the matching global xIE = 1.
- **Priority**, highest first: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5), then local lines with the highest index first, then UEI(8), USI(0), UTI(4).
- **Exceptions** always beat interrupts and always target M.
- **FSM states: IDLE, REQ, COMMIT.**
  - IDLE → REQ when `exc_flag` or any eligible interrupt is present. On that transition, register `trap_pc`, `trap_cause` and `trap_mode`, and assert `trap_req`.
  - REQ: hold all outputs stable until `trap_ack`. One exception: if `exc_flag` rises while REQ holds an interrupt, and `trap_ack` is low, the outputs are reloaded with the exception.
  - REQ and `trap_ack` → COMMIT: `mode` <= `trap_mode`; `trap_req` deasserts.
  - COMMIT → IDLE after one cycle. No arbitration happens in COMMIT, which lets CSR side effects settle.
- **Trap PC.**
  - base = tvec with bits [1:0] forced to 0.
  - If tvec[1:0] == 01 and the trap is an interrupt: `trap_pc` = base + 4·code. Otherwise `trap_pc` = base.
  - utvec is used only when target = U, which cannot occur without delegation and is reserved; treat it as M.
- **Return instructions**, honoured in IDLE only:
  - `mret`: `mode` <= `mpp`.
  - `sret`: `mode` <= {0, `spp`}.
  - `uret`: `mode` <= 0.
  - If a return and `exc_flag` arrive together, the exception wins and the return is dropped.
- **Arithmetic.** The PC add is PC_SZ wide and wraps modulo 2^PC_SZ.

## Timing
- **Reset values:**
  - `mode` = 3.
  - `trap_req` = 0.
  - `trap_pc` = 0.
  - `trap_cause` = 0.
  - `trap_mode` = 3.
  - `lip` = 0.
  - state = IDLE.
- Reset in REQ or COMMIT abandons the trap; the next cycle is IDLE with reset values.
- **Latency:**
  - Local line edge → `lip` set: 1 cycle.
  - `lip` → `trap_req`: 1 cycle.
  - `exc_flag` → `trap_req`: 1 cycle.
  - `trap_ack` → `mode` update: 1 cycle.
  - Minimum spacing between two traps: 3 cycles (REQ, COMMIT, IDLE).
- `trap_req` may be held for any number of cycles. An interrupt that loses eligibility while waiting in REQ is still delivered; WB decides via `trap_ack`.

## Structure
- Put these in `cpu_params_pkg`:
  - the priority order table;
  - cause code constants;
  - the FSM state enum `trap_state_t`;
  - the mode constants M/S/U.
- Sub-module `lirq_latch`, one instance per local line: edge detect, latch and clear logic, parametrised by edge/level.

## Test plan
- **Reset:** assert `reset_in` while in REQ → next cycle `mode` = 3, `trap_req` = 0, `lip` = 0.
- **Vectored local interrupt:** `mode` = M, `mstatus_mie` = 1, edge line 2 pulses, `lie[2]` = 1, `mtvec` = 0x1001 → `trap_req` 2 cycles after the pulse, `trap_cause` = 0x80000012, `trap_pc` = 0x1048.
- **Priority:** MTI and MEI pending and enabled together → `trap_cause` = 0x8000000B. After `trap_ack` with MEI cleared, the next trap is cause 0x80000007.
- **Exception pre-empts interrupt:** `exc_flag` (code 2) arrives while REQ holds MTI and `trap_ack` = 0 → `trap_cause` = 2 and `trap_pc` = `mtvec` base. After `trap_ack`, `mode` = 3 on the next cycle.
- **Delegation:** `mode` = U, SEI pending, `mideleg[9]` = 1, `stvec` = 0x2000 → `trap_mode` = 1, `trap_pc` = 0x2000. With `mode` = M instead, the same SEI is not taken.
- **Return instructions:** `mret` with `mpp` = 0 → `mode` = 0. `mret` together with `exc_flag` → `mode` stays 3 and `trap_req` rises.

Source files
------------

// File: rtl/cpu_params_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_params_pkg: shared RisKy1 constants for trap arbitration (modes, causes,
// interrupt priority order, trap FSM state).  Rev 1.0
// ----------------------------------------------------------------------------
package cpu_params_pkg;

  localparam logic [1:0] MODE_U = 2'd0;
  localparam logic [1:0] MODE_S = 2'd1;
  localparam logic [1:0] MODE_M = 2'd3;

  localparam int CAUSE_USI        = 0;
  localparam int CAUSE_SSI        = 1;
  localparam int CAUSE_MSI        = 3;
  localparam int CAUSE_UTI        = 4;
  localparam int CAUSE_STI        = 5;
  localparam int CAUSE_MTI        = 7;
  localparam int CAUSE_UEI        = 8;
  localparam int CAUSE_SEI        = 9;
  localparam int CAUSE_MEI        = 11;
  localparam int CAUSE_LOCAL_BASE = 16;
  localparam int NUM_STD_IRQ      = 12;

  // Local lines sit between the high and low standard groups
  localparam int NUM_PRIO_HI = 6;
  localparam int NUM_PRIO_LO = 3;
  localparam int PRIO_HI [NUM_PRIO_HI] = '{CAUSE_MEI, CAUSE_MSI, CAUSE_MTI,
                                           CAUSE_SEI, CAUSE_SSI, CAUSE_STI};
  localparam int PRIO_LO [NUM_PRIO_LO] = '{CAUSE_UEI, CAUSE_USI, CAUSE_UTI};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_COMMIT = 2'd2
  } trap_state_t;

endpackage
`default_nettype wire

// File: rtl/lirq_latch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lirq_latch: pending bit for one local interrupt line, edge-latched or level.
// Rev 1.0
// ----------------------------------------------------------------------------
module lirq_latch #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic lirq_in,
  input  logic clr,
  output logic lip
);

  logic r_lip;
  assign lip = r_lip;

  generate
    if (EDGE) begin : g_edge
      logic r_prev;
      // A new edge outranks a simultaneous clear so no event is lost
      always_ff @(posedge clk_in) begin
        if (reset_in) begin
          r_prev <= 1'b0;
          r_lip  <= 1'b0;
        end else begin
          r_prev <= lirq_in;
          if (lirq_in && !r_prev) begin
            r_lip <= 1'b1;
          end else if (clr) begin
            r_lip <= 1'b0;
          end
        end
      end
    end else begin : g_level
      logic w_unused_clr;
      assign w_unused_clr = clr;
      always_ff @(posedge clk_in) begin
        if (reset_in) begin
          r_lip <= 1'b0;
        end else begin
          r_lip <= lirq_in;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/trap_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trap_arbiter: interrupt/exception arbitration, delegation, WB handshake and
// privilege-mode ownership for RisKy1.  Rev 1.0
// ----------------------------------------------------------------------------
module trap_arbiter
  import cpu_params_pkg::*;
#(
  parameter int                   NUM_LOCAL = 4,
  parameter logic [NUM_LOCAL-1:0] EDGE_MASK = '0,
  parameter int                   PC_SZ     = 32,
  parameter int                   RSZ       = 32
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [NUM_LOCAL-1:0]      lirq_in,
  input  logic [NUM_LOCAL-1:0]      lie,
  input  logic [NUM_LOCAL-1:0]      lip_clr,
  output logic [NUM_LOCAL-1:0]      lip,
  input  logic [11:0]               mip,
  input  logic [11:0]               mie,
  input  logic [12+NUM_LOCAL-1:0]   mideleg,
  input  logic                      mstatus_mie,
  input  logic                      mstatus_sie,
  input  logic                      mstatus_uie,
  input  logic [1:0]                mpp,
  input  logic                      spp,
  input  logic [RSZ-1:0]            mtvec,
  input  logic [RSZ-1:0]            stvec,
  input  logic [RSZ-1:0]            utvec,
  input  logic                      exc_flag,
  input  logic [RSZ-2:0]            exc_cause,
  input  logic                      mret,
  input  logic                      sret,
  input  logic                      uret,
  output logic                      trap_req,
  input  logic                      trap_ack,
  output logic [PC_SZ-1:0]          trap_pc,
  output logic [RSZ-1:0]            trap_cause,
  output logic [1:0]                trap_mode,
  output logic [1:0]                mode
);

  localparam int NI = NUM_STD_IRQ + NUM_LOCAL;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LOCAL; gi++) begin : g_lirq
      lirq_latch #(.EDGE(EDGE_MASK[gi])) u_lirq_latch (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .lirq_in  (lirq_in[gi]),
        .clr      (lip_clr[gi]),
        .lip      (lip[gi])
      );
    end
  endgenerate

  trap_state_t          r_state;
  logic [1:0]           r_mode;
  logic                 r_req;
  logic [PC_SZ-1:0]     r_pc;
  logic [RSZ-1:0]       r_cause;
  logic [1:0]           r_tmode;
  logic                 r_is_irq;

  logic [NI-1:0]        w_cand;
  logic [NI-1:0]        w_to_s;
  logic [NI-1:0]        w_elig;
  logic                 w_gie;
  logic                 w_irq_found;
  logic [RSZ-2:0]       w_irq_code;
  logic                 w_irq_to_s;
  logic [RSZ-1:0]       w_irq_tvec;
  logic [PC_SZ-1:0]     w_irq_base;
  logic [PC_SZ-1:0]     w_irq_pc;
  logic [PC_SZ-1:0]     w_exc_pc;
  logic                 w_unused;

  // U-mode trap targets are reserved and routed to M, so utvec is never read
  assign w_unused = ^utvec;

  assign w_cand = {lip & lie, mip & mie};

  always_comb begin
    w_gie = mstatus_uie;
    if (r_mode == MODE_M) begin
      w_gie = mstatus_mie;
    end else if (r_mode == MODE_S) begin
      w_gie = mstatus_sie;
    end
  end

  always_comb begin
    w_to_s = '0;
    w_elig = '0;
    for (int j = 0; j < NI; j++) begin
      w_to_s[j] = mideleg[j] && (r_mode != MODE_M);
      w_elig[j] = w_cand[j] &&
                  (((w_to_s[j] ? MODE_S : MODE_M) > r_mode) ||
                   (((w_to_s[j] ? MODE_S : MODE_M) == r_mode) && w_gie));
    end
  end

  always_comb begin
    w_irq_found = 1'b0;
    w_irq_code  = '0;
    w_irq_to_s  = 1'b0;
    for (int k = 0; k < NUM_PRIO_HI; k++) begin
      if (!w_irq_found && w_elig[PRIO_HI[k]]) begin
        w_irq_found = 1'b1;
        w_irq_code  = (RSZ-1)'(PRIO_HI[k]);
        w_irq_to_s  = w_to_s[PRIO_HI[k]];
      end
    end
    for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
      if (!w_irq_found && w_elig[NUM_STD_IRQ + i]) begin
        w_irq_found = 1'b1;
        w_irq_code  = (RSZ-1)'(CAUSE_LOCAL_BASE + i);
        w_irq_to_s  = w_to_s[NUM_STD_IRQ + i];
      end
    end
    for (int k = 0; k < NUM_PRIO_LO; k++) begin
      if (!w_irq_found && w_elig[PRIO_LO[k]]) begin
        w_irq_found = 1'b1;
        w_irq_code  = (RSZ-1)'(PRIO_LO[k]);
        w_irq_to_s  = w_to_s[PRIO_LO[k]];
      end
    end
  end

  assign w_irq_tvec = w_irq_to_s ? stvec : mtvec;
  assign w_irq_base = PC_SZ'(w_irq_tvec) & ~PC_SZ'(3);
  assign w_irq_pc   = (w_irq_tvec[1:0] == 2'b01) ?
                      w_irq_base + (PC_SZ'(w_irq_code) << 2) : w_irq_base;
  assign w_exc_pc   = PC_SZ'(mtvec) & ~PC_SZ'(3);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_M;
      r_req    <= 1'b0;
      r_pc     <= '0;
      r_cause  <= '0;
      r_tmode  <= MODE_M;
      r_is_irq <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Traps outrank return instructions retiring in the same cycle
          if (exc_flag) begin
            r_pc     <= w_exc_pc;
            r_cause  <= {1'b0, exc_cause};
            r_tmode  <= MODE_M;
            r_is_irq <= 1'b0;
            r_req    <= 1'b1;
            r_state  <= ST_REQ;
          end else if (w_irq_found) begin
            r_pc     <= w_irq_pc;
            r_cause  <= {1'b1, w_irq_code};
            r_tmode  <= w_irq_to_s ? MODE_S : MODE_M;
            r_is_irq <= 1'b1;
            r_req    <= 1'b1;
            r_state  <= ST_REQ;
          end else if (mret) begin
            r_mode <= mpp;
          end else if (sret) begin
            r_mode <= {1'b0, spp};
          end else if (uret) begin
            r_mode <= MODE_U;
          end
        end
        ST_REQ: begin
          if (trap_ack) begin
            r_mode  <= r_tmode;
            r_req   <= 1'b0;
            r_state <= ST_COMMIT;
          end else if (exc_flag && r_is_irq) begin
            r_pc     <= w_exc_pc;
            r_cause  <= {1'b0, exc_cause};
            r_tmode  <= MODE_M;
            r_is_irq <= 1'b0;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign trap_req   = r_req;
  assign trap_pc    = r_pc;
  assign trap_cause = r_cause;
  assign trap_mode  = r_tmode;
  assign mode       = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_trap_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_trap_arbiter: directed table vectors plus hand-written handshake sequences.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_trap_arbiter;

  localparam int         NL = 4;
  localparam logic [3:0] EM = 4'b0100;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [NL-1:0]   lirq_in, lie, lip_clr, lip;
  logic [11:0]     mip, mie;
  logic [15:0]     mideleg;
  logic            mstatus_mie, mstatus_sie, mstatus_uie;
  logic [1:0]      mpp;
  logic            spp;
  logic [31:0]     mtvec, stvec, utvec;
  logic            exc_flag;
  logic [30:0]     exc_cause;
  logic            mret, sret, uret;
  logic            trap_req, trap_ack;
  logic [31:0]     trap_pc, trap_cause;
  logic [1:0]      trap_mode, mode;

  int n_checks = 0;
  int n_fail   = 0;

  trap_arbiter #(.NUM_LOCAL(NL), .EDGE_MASK(EM), .PC_SZ(32), .RSZ(32)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .lirq_in(lirq_in), .lie(lie), .lip_clr(lip_clr), .lip(lip),
    .mip(mip), .mie(mie), .mideleg(mideleg),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .mstatus_uie(mstatus_uie),
    .mpp(mpp), .spp(spp), .mtvec(mtvec), .stvec(stvec), .utvec(utvec),
    .exc_flag(exc_flag), .exc_cause(exc_cause),
    .mret(mret), .sret(sret), .uret(uret),
    .trap_req(trap_req), .trap_ack(trap_ack),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_mode(trap_mode), .mode(mode)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  vmode;
    logic [11:0] vmip;
    logic [11:0] vmie;
    logic [15:0] vdeleg;
    logic        gm;
    logic        gs;
    logic [31:0] vmtvec;
    logic [31:0] vstvec;
    logic        exp_req;
    logic [31:0] exp_cause;
    logic [31:0] exp_pc;
    logic [1:0]  exp_tmode;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    lirq_in = '0; lie = '0; lip_clr = '0;
    mip = '0; mie = '0; mideleg = '0;
    mstatus_mie = 0; mstatus_sie = 0; mstatus_uie = 0;
    mpp = 2'd3; spp = 0;
    mtvec = 32'h100; stvec = 32'h2000; utvec = 32'h3000;
    exc_flag = 0; exc_cause = '0;
    mret = 0; sret = 0; uret = 0; trap_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_in = 1;
    tick();
    tick();
    reset_in = 0;
  endtask

  // Reach the requested mode from M through mret while nothing is pending
  task automatic set_mode(input logic [1:0] m);
    if (m != 2'd3) begin
      mpp = m;
      mret = 1;
      tick();
      mret = 0;
      mpp = 2'd3;
    end
  endtask

  initial begin
    reset_in = 1;
    idle_inputs();

    //           mode   mip     mie     deleg   gm gs mtvec    stvec    req cause         pc          tmode
    vecs[0]  = '{2'd3, 12'h800, 12'h800, 16'h0,   1, 0, 32'h100, 32'h2000, 1, 32'h8000000B, 32'h100,  2'd3};
    vecs[1]  = '{2'd3, 12'h880, 12'h880, 16'h0,   1, 0, 32'h100, 32'h2000, 1, 32'h8000000B, 32'h100,  2'd3};
    vecs[2]  = '{2'd3, 12'h088, 12'h088, 16'h0,   1, 0, 32'h100, 32'h2000, 1, 32'h80000003, 32'h100,  2'd3};
    vecs[3]  = '{2'd3, 12'h080, 12'h080, 16'h0,   0, 0, 32'h100, 32'h2000, 0, 32'h0,        32'h0,    2'd3};
    vecs[4]  = '{2'd3, 12'h080, 12'h000, 16'h0,   1, 0, 32'h100, 32'h2000, 0, 32'h0,        32'h0,    2'd3};
    vecs[5]  = '{2'd3, 12'h080, 12'h080, 16'h0,   1, 0, 32'h101, 32'h2000, 1, 32'h80000007, 32'h11C,  2'd3};
    vecs[6]  = '{2'd0, 12'h200, 12'h200, 16'h200, 0, 0, 32'h100, 32'h2000, 1, 32'h80000009, 32'h2000, 2'd1};
    vecs[7]  = '{2'd3, 12'h200, 12'h200, 16'h200, 0, 0, 32'h100, 32'h2000, 0, 32'h0,        32'h0,    2'd3};
    vecs[8]  = '{2'd1, 12'h200, 12'h200, 16'h200, 0, 0, 32'h100, 32'h2000, 0, 32'h0,        32'h0,    2'd3};
    vecs[9]  = '{2'd1, 12'h200, 12'h200, 16'h200, 0, 1, 32'h100, 32'h2000, 1, 32'h80000009, 32'h2000, 2'd1};
    vecs[10] = '{2'd1, 12'h080, 12'h080, 16'h0,   0, 0, 32'h100, 32'h2000, 1, 32'h80000007, 32'h100,  2'd3};
    vecs[11] = '{2'd0, 12'h101, 12'h101, 16'h0,   0, 0, 32'h100, 32'h2000, 1, 32'h80000008, 32'h100,  2'd3};
    vecs[12] = '{2'd3, 12'h032, 12'h032, 16'h0,   1, 0, 32'h100, 32'h2000, 1, 32'h80000001, 32'h100,  2'd3};
    vecs[13] = '{2'd0, 12'h020, 12'h020, 16'h020, 0, 0, 32'h100, 32'h2001, 1, 32'h80000005, 32'h2014, 2'd1};

    // Reset values
    do_reset();
    chk("rst_mode", 64'(mode), 64'd3);
    chk("rst_req", 64'(trap_req), 64'd0);
    chk("rst_pc", 64'(trap_pc), 64'd0);
    chk("rst_cause", 64'(trap_cause), 64'd0);
    chk("rst_tmode", 64'(trap_mode), 64'd3);
    chk("rst_lip", 64'(lip), 64'd0);

    // Table: one arbitration decision per vector from a clean IDLE
    for (int v = 0; v < 14; v++) begin
      do_reset();
      mtvec = vecs[v].vmtvec;
      stvec = vecs[v].vstvec;
      set_mode(vecs[v].vmode);
      chk($sformatf("vec%0d_mode", v), 64'(mode), 64'(vecs[v].vmode));
      mip = vecs[v].vmip; mie = vecs[v].vmie; mideleg = vecs[v].vdeleg;
      mstatus_mie = vecs[v].gm; mstatus_sie = vecs[v].gs;
      tick();
      chk($sformatf("vec%0d_req", v), 64'(trap_req), 64'(vecs[v].exp_req));
      if (vecs[v].exp_req) begin
        chk($sformatf("vec%0d_cause", v), 64'(trap_cause), 64'(vecs[v].exp_cause));
        chk($sformatf("vec%0d_pc", v), 64'(trap_pc), 64'(vecs[v].exp_pc));
        chk($sformatf("vec%0d_tmode", v), 64'(trap_mode), 64'(vecs[v].exp_tmode));
      end
    end

    // Vectored edge-latched local line 2
    do_reset();
    mtvec = 32'h1001; mstatus_mie = 1; lie = 4'b0100;
    lirq_in = 4'b0100;
    tick();
    chk("loc_lip_set", 64'(lip), 64'h4);
    chk("loc_req_early", 64'(trap_req), 64'd0);
    lirq_in = 4'b0000;
    tick();
    chk("loc_req", 64'(trap_req), 64'd1);
    chk("loc_cause", 64'(trap_cause), 64'h80000012);
    chk("loc_pc", 64'(trap_pc), 64'h1048);
    chk("loc_lip_hold", 64'(lip), 64'h4);
    trap_ack = 1; lip_clr = 4'b0100;
    tick();
    chk("loc_ack_req", 64'(trap_req), 64'd0);
    chk("loc_lip_clr", 64'(lip), 64'h0);
    trap_ack = 0; lip_clr = 4'b0000;
    tick();
    tick();
    chk("loc_no_retrap", 64'(trap_req), 64'd0);
    lie = 4'b0000;
    lirq_in = 4'b0100; lip_clr = 4'b0100;
    tick();
    chk("loc_set_wins", 64'(lip[2]), 64'd1);
    lirq_in = 4'b1000; lip_clr = 4'b0000;
    tick();
    chk("lvl_follow", 64'(lip[3]), 64'd1);
    lip_clr = 4'b1000;
    tick();
    chk("lvl_clr_ignored", 64'(lip[3]), 64'd1);
    lirq_in = 4'b0000; lip_clr = 4'b0000;
    tick();
    chk("lvl_drop", 64'(lip[3]), 64'd0);

    // Local line outranks UEI
    do_reset();
    mstatus_mie = 1; lie = 4'b1000; lirq_in = 4'b1000;
    tick();
    mip = 12'h100; mie = 12'h100;
    tick();
    chk("locprio_cause", 64'(trap_cause), 64'h80000013);
    chk("locprio_pc", 64'(trap_pc), 64'h100);

    // Priority then 3-cycle spacing to the next trap
    do_reset();
    mstatus_mie = 1; mip = 12'h880; mie = 12'h880;
    tick();
    chk("prio_cause1", 64'(trap_cause), 64'h8000000B);
    trap_ack = 1; mip = 12'h080;
    tick();
    trap_ack = 0;
    chk("prio_commit_req", 64'(trap_req), 64'd0);
    tick();
    chk("prio_idle_req", 64'(trap_req), 64'd0);
    tick();
    chk("prio_req2", 64'(trap_req), 64'd1);
    chk("prio_cause2", 64'(trap_cause), 64'h80000007);

    // Exception pre-empts a waiting interrupt
    do_reset();
    set_mode(2'd0);
    mtvec = 32'h101; mip = 12'h080; mie = 12'h080;
    tick();
    chk("pre_irq_pc", 64'(trap_pc), 64'h11C);
    exc_flag = 1; exc_cause = 31'd2;
    tick();
    exc_flag = 0; mip = '0;
    chk("pre_exc_cause", 64'(trap_cause), 64'h2);
    chk("pre_exc_pc", 64'(trap_pc), 64'h100);
    chk("pre_exc_tmode", 64'(trap_mode), 64'd3);
    tick();
    chk("pre_hold", 64'(trap_cause), 64'h2);
    chk("pre_mode_before", 64'(mode), 64'd0);
    trap_ack = 1;
    tick();
    trap_ack = 0;
    chk("pre_mode_after", 64'(mode), 64'd3);
    chk("pre_req_after", 64'(trap_req), 64'd0);

    // Reset abandons a trap in REQ
    do_reset();
    set_mode(2'd0);
    mip = 12'h080; mie = 12'h080; lirq_in = 4'b0100;
    tick();
    chk("rreq_req", 64'(trap_req), 64'd1);
    chk("rreq_lip", 64'(lip), 64'h4);
    reset_in = 1;
    tick();
    chk("rreq_mode", 64'(mode), 64'd3);
    chk("rreq_reqclr", 64'(trap_req), 64'd0);
    chk("rreq_lipclr", 64'(lip), 64'h0);
    chk("rreq_cause", 64'(trap_cause), 64'h0);
    idle_inputs();
    reset_in = 0;
    tick();
    chk("rreq_idle", 64'(trap_req), 64'd0);

    // Return instructions
    do_reset();
    mpp = 2'd0; mret = 1;
    tick();
    mret = 0;
    chk("ret_mret", 64'(mode), 64'd0);
    spp = 1; sret = 1;
    tick();
    sret = 0;
    chk("ret_sret", 64'(mode), 64'd1);
    uret = 1;
    tick();
    uret = 0;
    chk("ret_uret", 64'(mode), 64'd0);
    mpp = 2'd3; mret = 1;
    tick();
    chk("ret_mret_m", 64'(mode), 64'd3);
    mpp = 2'd0; exc_flag = 1; exc_cause = 31'd5; mtvec = 32'h101;
    tick();
    mret = 0; exc_flag = 0;
    chk("ret_exc_mode", 64'(mode), 64'd3);
    chk("ret_exc_req", 64'(trap_req), 64'd1);
    chk("ret_exc_cause", 64'(trap_cause), 64'h5);
    chk("ret_exc_pc", 64'(trap_pc), 64'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
